rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Arbiter that shares the single-port synchronous instruction ROM between the fetch unit (ibus) and the load path of the memory stage (dbus, for constant/data reads from ROM). Grants one requester per cycle, drives the ROM word address, and routes the read data back to the owner one cycle later. Out-of-range addresses are flagged as access faults and never reach the ROM. A bounded-streak fairness rule prevents fetch starvation. Sits between the core's fetch/memory stages and the ROM macro.

## Interface
- WIDTH, 32, data and byte-address width
- ROM_ADDR_WIDTH, 10, ROM word-address width; ROM holds 2^ROM_ADDR_WIDTH words
- MAX_STREAK, 4, max consecutive dbus grants while ibus waits; legal range 1..15

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- ibus_req  in  1  fetch requests a read this cycle
- ibus_addr  in  WIDTH  fetch byte address
- ibus_gnt  out  1  fetch request accepted this cycle (combinational)
- ibus_rvalid  out  1  fetch response valid (cycle after grant)
- ibus_rdata  out  WIDTH  fetch read data
- ibus_fault  out  1  fetch access fault, qualified by ibus_rvalid
- dbus_req  in  1  load path requests a read this cycle
- dbus_addr  in  WIDTH  load byte address
- dbus_gnt  out  1  load request accepted this cycle (combinational)
- dbus_rvalid  out  1  load response valid (cycle after grant)
- dbus_rdata  out  WIDTH  load read data
- dbus_fault  out  1  load access fault, qualified by dbus_rvalid
- rom_en  out  1  ROM read enable
- rom_addr  out  ROM_ADDR_WIDTH  ROM word address
- rom_data  in  WIDTH  ROM read data, valid the cycle after rom_en

## Operation
- Word address = addr[ROM_ADDR_WIDTH+1:2]; addr[1:0] ignored.
- Fault = |addr[WIDTH-1:ROM_ADDR_WIDTH+2] of the granted request.
- Arbitration, per cycle, at most one gnt high:
  - only one req high -> that requester granted.
  - both high -> dbus granted, unless streak == MAX_STREAK, then ibus granted.
  - neither -> no grant, rom_en=0.
- Granted, non-faulting request -> rom_en=1, rom_addr=word address. Faulting request -> rom_en=0, rom_addr=0; still consumes the grant slot.
- Streak counter (4 bits): +1 when dbus granted while ibus_req=1; cleared when ibus granted or ibus_req=0; saturates at MAX_STREAK.
- Response registers: owner (NONE/IBUS/DBUS) and fault flag, loaded every cycle from the current grant.
  - owner=IBUS: ibus_rvalid=1, ibus_fault=fault flag, ibus_rdata = fault ? 0 : rom_data; dbus_* = 0.
  - owner=DBUS: symmetric.
  - owner=NONE: all rvalid/fault/rdata = 0.
- Requesters hold req/addr until gnt; an ungranted request is not latched (requester retries).

## Timing
- Grant: same cycle as req, combinational from req, addr and streak.
- Read latency: 1 cycle, gnt in cycle N -> rvalid/rdata in cycle N+1.
- Back-to-back: a new grant is legal in cycle N+1 while the response for N is returned; full throughput is 1 read/cycle.
- Reset (rst_n=0 at a rising edge): owner=NONE, fault flag=0, streak=0. While rst_n=0, both gnt and rom_en are forced to 0, and all rvalid/fault/rdata read 0.
- Reset mid-operation: a response due in the cycle after reset is dropped (rvalid stays 0). First grant is possible in the first cycle with rst_n=1.
- Simultaneous fault on the winner and a valid loser request: the loser still waits. No second grant in the same cycle.
- Streak boundary: with MAX_STREAK=4 and both requesting continuously, the grant pattern is D,D,D,D,I repeating.

## Test plan
- Reset: hold rst_n=0 with ibus_req=dbus_req=1 -> gnt=0, rom_en=0, all rvalid=0. Release reset -> dbus_gnt=1 in the first cycle.
- Single fetch: ibus_req=1, ibus_addr=0x0000_0ABC, ROM returns 0xDEAD_BEEF -> ibus_gnt=1, rom_addr=0x2AF; next cycle ibus_rvalid=1, ibus_rdata=0xDEAD_BEEF, ibus_fault=0.
- Fault: dbus_addr=0x0000_1000 (bit 12 set) -> dbus_gnt=1, rom_en=0; next cycle dbus_rvalid=1, dbus_fault=1, dbus_rdata=0.
- Contention/fairness: both req held for 10 cycles -> grant sequence D,D,D,D,I,D,D,D,D,I; the ibus response carries the ibus address data, never the dbus data.
- Reset mid-read: grant ibus in cycle N, rst_n=0 at the N+1 edge -> ibus_rvalid=0 in N+1, with no stale data afterward.
- Randomized: random req/addr for 128 cycles against a reference model -> at most one gnt per cycle, rom_addr and rdata/fault match the model, and no ibus wait exceeds MAX_STREAK grants.

Source files
------------

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the single-port instruction ROM between fetch (ibus)
// and the memory-stage load path (dbus). One grant per cycle, one-cycle read
// latency, out-of-range addresses are faulted without touching the ROM.
//
// Response owner register (loaded every cycle from the current grant):
//   state    | meaning
//   OWN_NONE | no read issued last cycle, all responses idle
//   OWN_IBUS | last cycle's grant went to fetch; its response is due now
//   OWN_DBUS | last cycle's grant went to the load path; its response is due now
module rom_arbiter #(
  parameter int WIDTH          = 32,
  parameter int ROM_ADDR_WIDTH = 10,
  parameter int MAX_STREAK     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ibus_req,
  input  logic [WIDTH-1:0]          ibus_addr,
  output logic                      ibus_gnt,
  output logic                      ibus_rvalid,
  output logic [WIDTH-1:0]          ibus_rdata,
  output logic                      ibus_fault,
  input  logic                      dbus_req,
  input  logic [WIDTH-1:0]          dbus_addr,
  output logic                      dbus_gnt,
  output logic                      dbus_rvalid,
  output logic [WIDTH-1:0]          dbus_rdata,
  output logic                      dbus_fault,
  output logic                      rom_en,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]          rom_data
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IBUS = 2'd1,
    OWN_DBUS = 2'd2
  } owner_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  owner_e owner_q, owner_d;
  logic   fault_q, fault_d;
  logic [3:0] streak_q, streak_d;

  logic [ROM_ADDR_WIDTH-1:0] ibus_word, dbus_word;
  logic ibus_oor, dbus_oor;

  // Byte-offset bits never select anything in a word-wide ROM.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{ibus_addr[1:0], dbus_addr[1:0]};

  assign ibus_word = ibus_addr[ROM_ADDR_WIDTH+1:2];
  assign dbus_word = dbus_addr[ROM_ADDR_WIDTH+1:2];
  assign ibus_oor  = |ibus_addr[WIDTH-1:ROM_ADDR_WIDTH+2];
  assign dbus_oor  = |dbus_addr[WIDTH-1:ROM_ADDR_WIDTH+2];

  // Arbitration, ROM drive and next owner/fault/streak; everything quiet in reset.
  always_comb begin
    ibus_gnt = 1'b0;
    dbus_gnt = 1'b0;
    owner_d  = OWN_NONE;
    fault_d  = 1'b0;
    streak_d = '0;
    rom_en   = 1'b0;
    rom_addr = '0;
    if (rst_n) begin
      // dbus wins ties until fetch has watched MAX_STREAK dbus grants in a row
      if (dbus_req && !(ibus_req && streak_q >= STREAK_MAX)) begin
        dbus_gnt = 1'b1;
        owner_d  = OWN_DBUS;
        fault_d  = dbus_oor;
      end else if (ibus_req) begin
        ibus_gnt = 1'b1;
        owner_d  = OWN_IBUS;
        fault_d  = ibus_oor;
      end
      // a faulting winner still burns the slot but keeps the ROM idle
      if (owner_d != OWN_NONE && !fault_d) begin
        rom_en   = 1'b1;
        rom_addr = dbus_gnt ? dbus_word : ibus_word;
      end
      if (dbus_gnt && ibus_req) begin
        streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
      end
    end
  end

  // Response and fairness state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      fault_q  <= 1'b0;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      fault_q  <= fault_d;
      streak_q <= streak_d;
    end
  end

  // Route ROM data to last cycle's owner; faults return zero data.
  always_comb begin
    ibus_rvalid = rst_n && (owner_q == OWN_IBUS);
    dbus_rvalid = rst_n && (owner_q == OWN_DBUS);
    ibus_fault  = ibus_rvalid && fault_q;
    dbus_fault  = dbus_rvalid && fault_q;
    ibus_rdata  = (ibus_rvalid && !fault_q) ? rom_data : '0;
    dbus_rdata  = (dbus_rvalid && !fault_q) ? rom_data : '0;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter: directed scenarios plus a randomized run against
// a transaction-level model of the arbitration and response rules.
module tb_rom_arbiter;

  localparam int WIDTH          = 32;
  localparam int ROM_ADDR_WIDTH = 10;
  localparam int MAX_STREAK     = 4;

  logic        clk;
  logic        rst_n;
  logic        ibus_req, dbus_req;
  logic [31:0] ibus_addr, dbus_addr;
  logic        ibus_gnt, dbus_gnt;
  logic        ibus_rvalid, dbus_rvalid;
  logic [31:0] ibus_rdata, dbus_rdata;
  logic        ibus_fault, dbus_fault;
  logic        rom_en;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;

  logic [31:0] mem [1024];

  int n_cmp = 0;
  int n_err = 0;

  rom_arbiter #(
    .WIDTH(WIDTH), .ROM_ADDR_WIDTH(ROM_ADDR_WIDTH), .MAX_STREAK(MAX_STREAK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
    .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata), .ibus_fault(ibus_fault),
    .dbus_req(dbus_req), .dbus_addr(dbus_addr), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .dbus_fault(dbus_fault),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM macro: synchronous read, output holds when not enabled
  always @(posedge clk) begin
    if (rom_en) rom_data <= mem[rom_addr];
  end

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return $urandom | 32'h0000_1000;
    return $urandom & 32'h0000_0FFF;
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #1;
    ibus_req = 1'b0; dbus_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ibus_req = 1'b1; dbus_req = 1'b1;
    ibus_addr = 32'h0000_0100; dbus_addr = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({ibus_gnt, dbus_gnt, rom_en} !== 3'b000) begin
        n_err++; $display("FAIL reset_gnt: got %b exp 000", {ibus_gnt, dbus_gnt, rom_en});
      end
      n_cmp++;
      if ({ibus_rvalid, dbus_rvalid, ibus_fault, dbus_fault} !== 4'b0000 ||
          ibus_rdata !== 32'h0 || dbus_rdata !== 32'h0) begin
        n_err++; $display("FAIL reset_resp: got rv=%b%b rd=%h/%h exp zeros",
                          ibus_rvalid, dbus_rvalid, ibus_rdata, dbus_rdata);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ibus_gnt, dbus_gnt} !== 2'b01) begin
      n_err++; $display("FAIL reset_release_gnt: got i/d=%b exp 01", {ibus_gnt, dbus_gnt});
    end
  endtask

  task automatic test_single_fetch();
    idle_cycle();
    @(posedge clk); #1;
    ibus_req = 1'b1; ibus_addr = 32'h0000_0ABC;
    @(negedge clk);
    n_cmp++;
    if ({ibus_gnt, dbus_gnt, rom_en} !== 3'b101 || rom_addr !== 10'h2AF) begin
      n_err++; $display("FAIL fetch_grant: got gnt=%b%b en=%b addr=%h exp 10 1 2af",
                        ibus_gnt, dbus_gnt, rom_en, rom_addr);
    end
    @(posedge clk); #1;
    ibus_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ibus_rvalid !== 1'b1 || ibus_rdata !== 32'hDEAD_BEEF || ibus_fault !== 1'b0) begin
      n_err++; $display("FAIL fetch_resp: got rv=%b rd=%h f=%b exp 1 deadbeef 0",
                        ibus_rvalid, ibus_rdata, ibus_fault);
    end
    n_cmp++;
    if (dbus_rvalid !== 1'b0 || dbus_rdata !== 32'h0) begin
      n_err++; $display("FAIL fetch_dbus_quiet: got rv=%b rd=%h exp 0 0", dbus_rvalid, dbus_rdata);
    end
  endtask

  task automatic test_fault();
    idle_cycle();
    @(posedge clk); #1;
    dbus_req = 1'b1; dbus_addr = 32'h0000_1000;
    ibus_req = 1'b1; ibus_addr = 32'h0000_0040;
    @(negedge clk);
    n_cmp++;
    if ({ibus_gnt, dbus_gnt, rom_en} !== 3'b010 || rom_addr !== 10'h0) begin
      n_err++; $display("FAIL fault_grant: got gnt=%b%b en=%b addr=%h exp 01 0 000",
                        ibus_gnt, dbus_gnt, rom_en, rom_addr);
    end
    @(posedge clk); #1;
    dbus_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dbus_rvalid !== 1'b1 || dbus_fault !== 1'b1 || dbus_rdata !== 32'h0) begin
      n_err++; $display("FAIL fault_resp: got rv=%b f=%b rd=%h exp 1 1 0",
                        dbus_rvalid, dbus_fault, dbus_rdata);
    end
    n_cmp++;
    if ({ibus_gnt, rom_en} !== 2'b11 || rom_addr !== 10'h010) begin
      n_err++; $display("FAIL fault_loser_retry: got gnt=%b en=%b addr=%h exp 1 1 010",
                        ibus_gnt, rom_en, rom_addr);
    end
    @(posedge clk); #1;
    ibus_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ibus_rvalid !== 1'b1 || ibus_rdata !== mem[16] || ibus_fault !== 1'b0) begin
      n_err++; $display("FAIL fault_loser_resp: got rv=%b rd=%h exp 1 %h",
                        ibus_rvalid, ibus_rdata, mem[16]);
    end
  endtask

  task automatic test_contention();
    bit prev_i;
    idle_cycle();
    prev_i = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      ibus_req = (k < 10); dbus_req = (k < 10);
      ibus_addr = 32'h0000_0100; dbus_addr = 32'h0000_0200;
      @(negedge clk);
      if (k > 0) begin
        n_cmp++;
        if (prev_i ? (ibus_rvalid !== 1'b1 || ibus_rdata !== mem[10'h040] || dbus_rvalid !== 1'b0)
                   : (dbus_rvalid !== 1'b1 || dbus_rdata !== mem[10'h080] || ibus_rvalid !== 1'b0)) begin
          n_err++; $display("FAIL contention_resp[%0d]: got irv=%b ird=%h drv=%b drd=%h exp owner_i=%b",
                            k, ibus_rvalid, ibus_rdata, dbus_rvalid, dbus_rdata, prev_i);
        end
      end
      if (k < 10) begin
        prev_i = (k % 5 == 4);
        n_cmp++;
        if ({ibus_gnt, dbus_gnt} !== {prev_i, ~prev_i}) begin
          n_err++; $display("FAIL contention_gnt[%0d]: got i/d=%b%b exp %b%b",
                            k, ibus_gnt, dbus_gnt, prev_i, ~prev_i);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    idle_cycle();
    @(posedge clk); #1;
    ibus_req = 1'b1; ibus_addr = 32'h0000_0ABC;
    @(negedge clk);
    n_cmp++;
    if (ibus_gnt !== 1'b1) begin
      n_err++; $display("FAIL midreset_gnt: got %b exp 1", ibus_gnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b0; ibus_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ibus_rvalid !== 1'b0 || ibus_rdata !== 32'h0 || ibus_fault !== 1'b0) begin
      n_err++; $display("FAIL midreset_drop: got rv=%b rd=%h exp 0 0", ibus_rvalid, ibus_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({ibus_rvalid, dbus_rvalid} !== 2'b00 || ibus_rdata !== 32'h0 || dbus_rdata !== 32'h0) begin
        n_err++; $display("FAIL midreset_stale[%0d]: got rv=%b%b rd=%h exp 00 0",
                          i, ibus_rvalid, dbus_rvalid, ibus_rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int          streak_m, wait_i;
    bit          pv_i, pv_d, pf_m, hold_i, hold_d, ei, ed, fault_m, en_m;
    logic [31:0] pdat, waddr;
    logic [9:0]  word_m;
    idle_cycle();
    streak_m = 0; wait_i = 0;
    pv_i = 0; pv_d = 0; pf_m = 0; pdat = '0; hold_i = 0; hold_d = 0;
    for (int c = 0; c <= 128; c++) begin
      @(posedge clk); #1;
      if (!hold_i) begin ibus_req = ($urandom_range(0, 3) != 0); ibus_addr = rand_addr(); end
      if (!hold_d) begin dbus_req = ($urandom_range(0, 3) != 0); dbus_addr = rand_addr(); end
      if (c == 128) begin ibus_req = 1'b0; dbus_req = 1'b0; end
      @(negedge clk);
      n_cmp++;
      if (ibus_rvalid !== pv_i || ibus_fault !== (pv_i && pf_m) ||
          ibus_rdata !== ((pv_i && !pf_m) ? pdat : 32'h0)) begin
        n_err++; $display("FAIL rand_ibus_resp[%0d]: got rv=%b f=%b rd=%h exp %b %b %h", c,
                          ibus_rvalid, ibus_fault, ibus_rdata, pv_i, pv_i && pf_m,
                          (pv_i && !pf_m) ? pdat : 32'h0);
      end
      n_cmp++;
      if (dbus_rvalid !== pv_d || dbus_fault !== (pv_d && pf_m) ||
          dbus_rdata !== ((pv_d && !pf_m) ? pdat : 32'h0)) begin
        n_err++; $display("FAIL rand_dbus_resp[%0d]: got rv=%b f=%b rd=%h exp %b %b %h", c,
                          dbus_rvalid, dbus_fault, dbus_rdata, pv_d, pv_d && pf_m,
                          (pv_d && !pf_m) ? pdat : 32'h0);
      end
      ed = dbus_req && !(ibus_req && streak_m >= MAX_STREAK);
      ei = ibus_req && !ed;
      n_cmp++;
      if (ibus_gnt !== ei || dbus_gnt !== ed || (ibus_gnt && dbus_gnt)) begin
        n_err++; $display("FAIL rand_gnt[%0d]: got i/d=%b%b exp %b%b", c, ibus_gnt, dbus_gnt, ei, ed);
      end
      waddr   = ed ? dbus_addr : ibus_addr;
      fault_m = (ei || ed) && (waddr >= 32'h0000_1000);
      word_m  = 10'((waddr >> 2) % 1024);
      en_m    = (ei || ed) && !fault_m;
      n_cmp++;
      if (rom_en !== en_m || rom_addr !== (en_m ? word_m : 10'h0)) begin
        n_err++; $display("FAIL rand_rom[%0d]: got en=%b addr=%h exp %b %h", c,
                          rom_en, rom_addr, en_m, en_m ? word_m : 10'h0);
      end
      if (ibus_req && !ibus_gnt) wait_i++;
      else wait_i = 0;
      n_cmp++;
      if (wait_i > MAX_STREAK) begin
        n_err++; $display("FAIL rand_starve[%0d]: got wait=%0d exp <=%0d", c, wait_i, MAX_STREAK);
      end
      pv_i = ei; pv_d = ed; pf_m = fault_m; pdat = mem[word_m];
      streak_m = (ed && ibus_req) ? streak_m + 1 : 0;
      hold_i = ibus_req && !ei;
      hold_d = dbus_req && !ed;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A5A_0000 ^ (i * 32'h9E37_79B9);
    mem[10'h2AF] = 32'hDEAD_BEEF;
    rom_data = '0;
    ibus_req = 1'b0; dbus_req = 1'b0; ibus_addr = '0; dbus_addr = '0;
    rst_n = 1'b0;
    test_reset();
    test_single_fetch();
    test_fault();
    test_contention();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
